// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for the DIV (signed) and UDIV
// (unsigned) ALU opcodes. One quotient bit is produced per clock on the
// operand magnitudes; the sign is applied as the result is registered.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_wr           start strobe, accepted only while o_busy is low
//   i_signed       1 = signed divide, 0 = unsigned (sampled with i_wr)
//   i_numerator    dividend (sampled with i_wr)
//   i_denominator  divisor (sampled with i_wr)
//   o_busy         high while a division is iterating
//   o_valid        one-cycle completion pulse
//   o_err          divide-by-zero flag, qualified by o_valid
//   o_quotient     result, held until the next completion
module div_unit #(
    parameter int unsigned BW   = 32,
    parameter int unsigned LGBW = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic          i_signed,
    input  logic [BW-1:0] i_numerator,
    input  logic [BW-1:0] i_denominator,
    output logic          o_busy,
    output logic          o_valid,
    output logic          o_err,
    output logic [BW-1:0] o_quotient
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [BW-1:0]   dividend;   // shifts out dividend MSBs, shifts in quotient bits
    logic [BW-1:0]   divisor;    // divisor magnitude
    logic [BW-1:0]   rem;        // partial remainder, always < divisor
    logic            neg_result;
    logic [LGBW-1:0] count;

    // Operand magnitudes at the start edge; abs(0x80000000) stays 0x80000000
    // and is then treated as unsigned.
    logic [BW-1:0] num_mag;
    logic [BW-1:0] den_mag;
    assign num_mag = (i_signed && i_numerator[BW-1])   ? BW'(-i_numerator)   : i_numerator;
    assign den_mag = (i_signed && i_denominator[BW-1]) ? BW'(-i_denominator) : i_denominator;

    // One restoring step: the shifted remainder needs one extra bit.
    logic [BW:0]   rem_shift;
    logic [BW:0]   rem_diff;
    logic          q_bit;
    logic [BW-1:0] q_next;
    assign rem_shift = {rem, dividend[BW-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor};
    assign q_bit     = (rem_shift >= {1'b0, divisor});
    assign q_next    = {dividend[BW-2:0], q_bit};

    // Control FSM and datapath
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            dividend   <= '0;
            divisor    <= '0;
            rem        <= '0;
            neg_result <= 1'b0;
            count      <= '0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_quotient <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_wr) begin
                        o_err <= 1'b0;
                        if (i_denominator == '0) begin
                            // Divide-by-zero completes immediately without iterating.
                            o_valid    <= 1'b1;
                            o_err      <= 1'b1;
                            o_quotient <= '0;
                        end else begin
                            dividend   <= num_mag;
                            divisor    <= den_mag;
                            rem        <= '0;
                            neg_result <= i_signed & (i_numerator[BW-1] ^ i_denominator[BW-1]);
                            count      <= LGBW'(BW - 1);
                            o_busy     <= 1'b1;
                            state      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem      <= q_bit ? rem_diff[BW-1:0] : rem_shift[BW-1:0];
                    dividend <= q_next;
                    count    <= count - LGBW'(1);
                    if (count == '0) begin
                        // Last bit: sign-correct and publish in the same edge.
                        o_quotient <= neg_result ? BW'(-q_next) : q_next;
                        o_err      <= 1'b0;
                        o_valid    <= 1'b1;
                        o_busy     <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with hand-computed quotients for div_unit.
module tb_div_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wr;
    logic        i_signed;
    logic [31:0] i_numerator;
    logic [31:0] i_denominator;
    logic        o_busy;
    logic        o_valid;
    logic        o_err;
    logic [31:0] o_quotient;

    int checks = 0;
    int errors = 0;

    div_unit #(.BW(32), .LGBW(5)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wr          (i_wr),
        .i_signed      (i_signed),
        .i_numerator   (i_numerator),
        .i_denominator (i_denominator),
        .o_busy        (o_busy),
        .o_valid       (o_valid),
        .o_err         (o_err),
        .o_quotient    (o_quotient)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one division and follow it to completion. Latency counts the
    // cycle right after the start edge as 1. A nonzero inject cycle pulses a
    // second i_wr with unrelated operands while the first is running.
    task automatic run_div(input string tag, input logic [31:0] num, input logic [31:0] den,
                           input logic sgn, input logic [31:0] exp_q, input logic exp_err,
                           input int exp_lat, input int exp_busy, input int inject);
        int lat;
        int busy_cnt;
        int extra;
        @(negedge i_clk);
        i_wr          = 1'b1;
        i_signed      = sgn;
        i_numerator   = num;
        i_denominator = den;
        @(posedge i_clk);
        #1;
        i_wr          = 1'b0;
        i_numerator   = 32'hDEAD_BEEF;
        i_denominator = 32'h0000_0000;
        lat      = 1;
        busy_cnt = 0;
        while (!o_valid && lat <= 60) begin
            if (o_busy) busy_cnt++;
            if (lat == inject) begin
                i_wr          = 1'b1;
                i_signed      = 1'b1;
                i_numerator   = 32'd77;
                i_denominator = 32'd7;
            end
            @(posedge i_clk);
            #1;
            i_wr = 1'b0;
            lat++;
        end
        check_eq({tag, " valid"},    32'(o_valid), 32'd1);
        check_eq({tag, " latency"},  32'(lat), 32'(exp_lat));
        check_eq({tag, " busy_cyc"}, 32'(busy_cnt), 32'(exp_busy));
        check_eq({tag, " busy_end"}, 32'(o_busy), 32'd0);
        check_eq({tag, " quotient"}, o_quotient, exp_q);
        check_eq({tag, " err"},      32'(o_err), 32'(exp_err));
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) extra++;
        end
        check_eq({tag, " extra_valid"}, 32'(extra), 32'd0);
        check_eq({tag, " q_hold"},      o_quotient, exp_q);
    endtask

    initial begin
        int valid_seen;
        i_reset       = 1'b1;
        i_wr          = 1'b0;
        i_signed      = 1'b0;
        i_numerator   = '0;
        i_denominator = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("reset busy",     32'(o_busy), 32'd0);
        check_eq("reset valid",    32'(o_valid), 32'd0);
        check_eq("reset err",      32'(o_err), 32'd0);
        check_eq("reset quotient", o_quotient, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        run_div("u100/7",     32'd100,         32'd7,           1'b0, 32'd14,          1'b0, 33, 32, 0);
        run_div("s-100/7",    32'hFFFF_FF9C,   32'd7,           1'b1, 32'hFFFF_FFF2,   1'b0, 33, 32, 0);
        run_div("s100/-7",    32'd100,         32'hFFFF_FFF9,   1'b1, 32'hFFFF_FFF2,   1'b0, 33, 32, 0);
        run_div("s-100/-7",   32'hFFFF_FF9C,   32'hFFFF_FFF9,   1'b1, 32'd14,          1'b0, 33, 32, 0);
        run_div("uFFFFFF9C/7",32'hFFFF_FF9C,   32'd7,           1'b0, 32'h2492_4916,   1'b0, 33, 32, 0);
        run_div("s5/0",       32'd5,           32'd0,           1'b1, 32'd0,           1'b1, 1,  0,  0);
        run_div("u5/0",       32'd5,           32'd0,           1'b0, 32'd0,           1'b1, 1,  0,  0);
        run_div("uMAX/1",     32'hFFFF_FFFF,   32'd1,           1'b0, 32'hFFFF_FFFF,   1'b0, 33, 32, 0);
        run_div("sMIN/-1",    32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   1'b0, 33, 32, 0);
        run_div("u3/10",      32'd3,           32'd10,          1'b0, 32'd0,           1'b0, 33, 32, 0);
        run_div("u1000/10 wr_mid", 32'd1000,   32'd10,          1'b0, 32'd100,         1'b0, 33, 32, 10);

        // Reset in flight: the aborted division must never complete.
        @(negedge i_clk);
        i_wr          = 1'b1;
        i_signed      = 1'b0;
        i_numerator   = 32'd1000;
        i_denominator = 32'd10;
        @(negedge i_clk);
        i_wr = 1'b0;
        repeat (10) @(negedge i_clk);
        check_eq("midrun busy", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        check_eq("abort busy",     32'(o_busy), 32'd0);
        check_eq("abort valid",    32'(o_valid), 32'd0);
        check_eq("abort quotient", o_quotient, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) valid_seen++;
            if (o_busy)  valid_seen++;
        end
        check_eq("abort no_activity", 32'(valid_seen), 32'd0);

        run_div("u9/3 after reset", 32'd9, 32'd3, 1'b0, 32'd3, 1'b0, 33, 32, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
